// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
//   True/False : single-bit logic constants
//   ZeroWord   : all-zero data word at the default width
//   *_DEF      : default data width, register count and producer-tag width
package regfile_sb_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int TAGW_DEF = 4;

  localparam logic [XLEN_DEF-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy/tag scoreboard for the register file.
// Ports:
//   clk, rst              : clock, async active-low reset
//   we/waddr/wtag         : write ports; a matching tag on a busy register clears it
//   iss_valid/iss_rd/iss_tag : issue marks destination busy with a new tag
//   flush                 : clears every busy bit and tag (issue that cycle dropped)
//   busy, tags            : registered busy bits and per-register tags
//   clr                   : combinational per-register "cleared this cycle" vector
//   busy_cnt              : registered count of busy registers
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NWR  = 2,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*TAGW-1:0]  wtag,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [TAGW-1:0]      iss_tag,
  input  logic                 flush,
  output logic [NREG-1:0]      busy,
  output logic [NREG*TAGW-1:0] tags,
  output logic [NREG-1:0]      clr,
  output logic [AW:0]          busy_cnt
);

  logic [NREG-1:0]      busy_n;
  logic [NREG*TAGW-1:0] tags_n;
  logic [AW:0]          cnt_n;

  // A write only retires the producer it carries the tag for; stale tags
  // (an older producer of a since-reissued register) leave busy alone.
  always_comb begin
    clr = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && busy[r] && (waddr[j*AW +: AW] == AW'(r)) &&
            (wtag[j*TAGW +: TAGW] == tags[r*TAGW +: TAGW]))
          clr[r] = True;
      end
    end
  end

  // Issue beats a same-cycle clear; flush beats both. Register 0 never tracked.
  always_comb begin
    busy_n = busy;
    tags_n = tags;
    if (flush) begin
      busy_n = '0;
      tags_n = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_valid && (iss_rd == AW'(r))) begin
          busy_n[r]               = True;
          tags_n[r*TAGW +: TAGW]  = iss_tag;
        end else if (clr[r]) begin
          busy_n[r]               = False;
          tags_n[r*TAGW +: TAGW]  = '0;
        end
      end
    end
    cnt_n = '0;
    for (int r = 1; r < NREG; r++)
      cnt_n = cnt_n + (AW+1)'(busy_n[r]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      tags     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_n;
      tags     <= tags_n;
      busy_cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with producer scoreboard.
// Ports:
//   clk, rst            : clock, async active-low reset
//   re/raddr            : NRD read ports -> rdata/rbusy/rtag (combinational, zero when
//                         the port is disabled or reset is asserted)
//   we/waddr/wdata/wtag : NWR write ports, highest index wins on address collision
//   iss_valid/iss_rd/iss_tag : issue marks destination busy
//   flush               : drops all busy state
//   busy_cnt            : registered count of busy registers
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 4,
  parameter int NWR  = 2,
  parameter int TAGW = TAGW_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic [NRD*TAGW-1:0] rtag,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NWR*TAGW-1:0] wtag,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [TAGW-1:0]     iss_tag,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]      regs [NREG];
  logic [NREG-1:0]      busy;
  logic [NREG*TAGW-1:0] tags;
  logic [NREG-1:0]      clr;

  regfile_scoreboard #(
    .NREG(NREG), .AW(AW), .NWR(NWR), .TAGW(TAGW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wtag     (wtag),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_tag  (iss_tag),
    .flush    (flush),
    .busy     (busy),
    .tags     (tags),
    .clr      (clr),
    .busy_cnt (busy_cnt)
  );

  // Data array. Ascending port loop makes the highest-index port's NBA land last.
  // regs[0] is only ever reset, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= ZeroWord[XLEN-1:0];
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (waddr[j*AW +: AW] == AW'(r)))
            regs[r] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: write-data bypass, busy as seen after this cycle's clears
  // (same-cycle issues are deliberately not forwarded).
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    logic [TAGW-1:0] t;

    assign a = raddr[i*AW +: AW];

    always_comb begin
      d = ZeroWord[XLEN-1:0];
      b = False;
      t = '0;
      if (rst && re[i] && (a != '0)) begin
        d = regs[a];
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (waddr[j*AW +: AW] == a))
            d = wdata[j*XLEN +: XLEN];
        end
        b = busy[a] & ~clr[a];
        if (b) t = tags[a*TAGW +: TAGW];
      end
    end

    assign rdata[i*XLEN +: XLEN] = d;
    assign rbusy[i]              = b;
    assign rtag[i*TAGW +: TAGW]  = t;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN = 32, NREG = 32, NRD = 4, NWR = 2, TAGW = 4, AW = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NRD*TAGW-1:0] rtag;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NWR*TAGW-1:0] wtag;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [TAGW-1:0]     iss_tag;
  logic                flush;
  logic [AW:0]         busy_cnt;

  regfile_sb dut (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .rtag(rtag), .we(we), .waddr(waddr), .wdata(wdata), .wtag(wtag),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic exp(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.nm, obs, e.v);
      end
    end
  endtask

  function automatic logic [31:0] rd_d(input int i);
    return rdata[i*XLEN +: XLEN];
  endfunction
  function automatic logic [31:0] rd_b(input int i);
    return 32'(rbusy[i]);
  endfunction
  function automatic logic [31:0] rd_t(input int i);
    return 32'(rtag[i*TAGW +: TAGW]);
  endfunction
  function automatic logic [31:0] cnt();
    return 32'(busy_cnt);
  endfunction

  task automatic idle();
    re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0; wtag = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_tag = '0; flush = 1'b0;
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d, input int t);
    we[j] = 1'b1;
    waddr[j*AW +: AW] = AW'(a);
    wdata[j*XLEN +: XLEN] = d;
    wtag[j*TAGW +: TAGW] = TAGW'(t);
  endtask

  task automatic rd(input int i, input int a);
    re[i] = 1'b1;
    raddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic iss(input int a, input int t);
    iss_valid = 1'b1;
    iss_rd = AW'(a);
    iss_tag = TAGW'(t);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b0;
    rd(0, 5);
    #2;
    exp("rst_rdata", 32'h0); chk(rd_d(0));
    exp("rst_rbusy", 32'h0); chk(rd_b(0));
    exp("rst_cnt",   32'h0); chk(cnt());
    #10 rst = 1'b1;
    tick();

    // write x5, read back next cycle
    wr(0, 5, 32'hDEADBEEF, 0);
    tick();
    rd(0, 5); #2;
    exp("x5_rdata", 32'hDEADBEEF); chk(rd_d(0));
    exp("x5_rbusy", 32'h0);        chk(rd_b(0));

    // same-cycle bypass, x0 write ignored, disabled port reads zero
    tick();
    wr(0, 3, 32'h11, 0); wr(1, 0, 32'hFFFF, 0);
    rd(0, 3); rd(1, 0); raddr[2*AW +: AW] = 5'd3; #2;
    exp("byp_x3",    32'h11); chk(rd_d(0));
    exp("byp_x0",    32'h0);  chk(rd_d(1));
    exp("re0_rdata", 32'h0);  chk(rd_d(2));
    tick();
    rd(0, 3); rd(1, 0); #2;
    exp("x3_stored", 32'h11); chk(rd_d(0));
    exp("x0_stored", 32'h0);  chk(rd_d(1));

    // two ports hit x7: port 1 wins
    tick();
    wr(0, 7, 32'hAA, 0); wr(1, 7, 32'hBB, 0); rd(3, 7); #2;
    exp("x7_byp", 32'hBB); chk(rd_d(3));
    tick();
    rd(3, 7); #2;
    exp("x7_stored", 32'hBB); chk(rd_d(3));

    // issue x9 tag 2, stale write tag 1, then matching write tag 2
    tick();
    iss(9, 2); rd(0, 9); #2;
    exp("iss_not_fwd", 32'h0); chk(rd_b(0));
    tick();
    exp("cnt_after_iss", 32'h1); chk(cnt());
    rd(0, 9); #2;
    exp("x9_busy", 32'h1); chk(rd_b(0));
    exp("x9_tag",  32'h2); chk(rd_t(0));
    tick();
    wr(0, 9, 32'h123, 1); rd(0, 9); #2;
    exp("stale_byp_busy", 32'h1);   chk(rd_b(0));
    exp("stale_byp_data", 32'h123); chk(rd_d(0));
    tick();
    rd(0, 9); #2;
    exp("stale_data", 32'h123); chk(rd_d(0));
    exp("stale_busy", 32'h1);   chk(rd_b(0));
    exp("stale_tag",  32'h2);   chk(rd_t(0));
    tick();
    wr(1, 9, 32'h456, 2); rd(0, 9); #2;
    exp("clr_byp_busy", 32'h0);   chk(rd_b(0));
    exp("clr_byp_tag",  32'h0);   chk(rd_t(0));
    exp("clr_byp_data", 32'h456); chk(rd_d(0));
    tick();
    exp("cnt_after_clr", 32'h0); chk(cnt());
    rd(0, 9); #2;
    exp("x9_idle", 32'h0); chk(rd_b(0));

    // issue beats a same-cycle clear on the same register
    tick();
    iss(10, 3);
    tick();
    wr(0, 10, 32'h77, 3); iss(10, 5);
    tick();
    exp("iss_win_cnt", 32'h1); chk(cnt());
    rd(1, 10); #2;
    exp("iss_win_busy", 32'h1); chk(rd_b(1));
    exp("iss_win_tag",  32'h5); chk(rd_t(1));
    tick();
    wr(0, 10, 32'h78, 5);
    tick();
    exp("x10_cleared_cnt", 32'h0); chk(cnt());

    // x0 issue ignored, three issues, then flush with issue and write
    iss(0, 1);
    tick();
    exp("x0_iss_cnt", 32'h0); chk(cnt());
    iss(1, 1); tick();
    iss(2, 2); tick();
    iss(4, 3); tick();
    exp("cnt3", 32'h3); chk(cnt());
    flush = 1'b1; iss(6, 4); wr(0, 1, 32'hCAFE, 1);
    tick();
    exp("flush_cnt", 32'h0); chk(cnt());
    rd(0, 6); rd(1, 1); #2;
    exp("flush_x6_busy", 32'h0);     chk(rd_b(0));
    exp("flush_x1_data", 32'hCAFE);  chk(rd_d(1));
    exp("flush_x1_busy", 32'h0);     chk(rd_b(1));

    // async reset mid-cycle with x5 busy
    tick();
    iss(5, 7);
    tick();
    rd(0, 5); #1;
    exp("pre_rst_busy", 32'h1);        chk(rd_b(0));
    exp("pre_rst_tag",  32'h7);        chk(rd_t(0));
    exp("pre_rst_data", 32'hDEADBEEF); chk(rd_d(0));
    rst = 1'b0; #1;
    exp("rst_now_data", 32'h0); chk(rd_d(0));
    exp("rst_now_busy", 32'h0); chk(rd_b(0));
    exp("rst_now_tag",  32'h0); chk(rd_t(0));
    exp("rst_now_cnt",  32'h0); chk(cnt());
    iss(5, 7); wr(0, 5, 32'h1234, 7);
    @(posedge clk); #2;
    idle();
    rst = 1'b1;
    tick();
    rd(0, 5); #2;
    exp("post_rst_data", 32'h0); chk(rd_d(0));
    exp("post_rst_busy", 32'h0); chk(rd_b(0));
    exp("post_rst_cnt",  32'h0); chk(cnt());

    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
